// File: rtl/dmem_pkg.sv
// Shared types and constants for the boot-loaded data memory.
package dmem_pkg;

   typedef enum logic [1:0] {LOAD, CLEAR, RUN} state_e;

   localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_loader_if.sv
// CPU data bus and loader stream of the data memory.
interface dmem_loader_if;

   logic        MemWrite;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_ready;

   modport master (
      output MemWrite, Addr, WriteData, ld_valid, ld_data, ld_last,
      input  ReadData, ld_ready
   );

   modport slave (
      input  MemWrite, Addr, WriteData, ld_valid, ld_data, ld_last,
      output ReadData, ld_ready
   );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
module dmem_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_loader.sv
// Data memory with boot loader: LOAD image, CLEAR the remainder, then RUN the CPU.
// Optional DMEM_ALIGN_CHECK_EN makes misaligned CPU accesses fault.
module dmem_loader
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR
) (
   input  logic                      clk,
   input  logic                      reset,
   dmem_loader_if.slave              bus,
   output logic                      cpu_hold,
   output logic [$clog2(DEPTH):0]    load_count,
   output logic                      addr_fault
);

   localparam int unsigned   AW       = idx_width(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_e        state_q;
   logic [AW-1:0] ptr_q;
   logic          ld_ready_q;

   logic [31:0]   off;
   logic          in_range;
   logic          misalign;
   logic          cpu_ok;
   logic [AW-1:0] cpu_idx;
   logic          accept;

   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;

   // Wrap-around subtraction makes addresses below the base land far out of range.
   assign off      = bus.Addr - BASE_ADDR;
   assign in_range = off < 32'(4 * DEPTH);
   assign cpu_idx  = off[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misalign = bus.Addr[1:0] != 2'b00;
`else
   assign misalign = 1'b0;
`endif

   assign cpu_ok = in_range & ~misalign;
   assign accept = ld_ready_q & bus.ld_valid;

   always_comb begin
      we    = 1'b0;
      waddr = ptr_q;
      wdata = bus.ld_data;
      unique case (state_q)
         LOAD:  we = accept;
         CLEAR: begin
            we    = 1'b1;
            wdata = '0;
         end
         RUN: begin
            we    = bus.MemWrite & cpu_ok;
            waddr = cpu_idx;
            wdata = bus.WriteData;
         end
         default: we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LOAD;
         ptr_q      <= '0;
         ld_ready_q <= 1'b1;
         cpu_hold   <= 1'b1;
         load_count <= '0;
         addr_fault <= 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (accept) begin
                  ptr_q      <= ptr_q + 1'b1;
                  load_count <= load_count + 1'b1;
                  if (ptr_q == LAST_IDX) begin
                     state_q    <= RUN;
                     ld_ready_q <= 1'b0;
                     cpu_hold   <= 1'b0;
                  end else if (bus.ld_last) begin
                     state_q    <= CLEAR;
                     ld_ready_q <= 1'b0;
                  end
               end
            end
            CLEAR: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == LAST_IDX) begin
                  state_q  <= RUN;
                  cpu_hold <= 1'b0;
               end
            end
            RUN: begin
               // The bus has no read strobe: every RUN cycle is an access.
               if (!cpu_ok) begin
                  addr_fault <= 1'b1;
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (cpu_idx),
      .rdata (rdata)
   );

   assign bus.ld_ready = ld_ready_q;
   assign bus.ReadData = (state_q == RUN && cpu_ok) ? rdata : 32'h0;

endmodule

// File: tb/tb_dmem_loader.sv
// Directed self-checking bench for dmem_loader with DEPTH=8.
module tb_dmem_loader;

   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h1001_0000;

   logic       clk;
   logic       reset;
   logic       cpu_hold;
   logic [3:0] load_count;
   logic       addr_fault;

   int n_checks;
   int n_fail;

   dmem_loader_if bus ();

   dmem_loader #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .cpu_hold   (cpu_hold),
      .load_count (load_count),
      .addr_fault (addr_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset            = 1'b1;
      bus.ld_valid     = 1'b0;
      bus.ld_last      = 1'b0;
      bus.ld_data      = '0;
      bus.MemWrite     = 1'b0;
      bus.WriteData    = '0;
      bus.Addr         = BASE;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
   endtask

   // Cycles until cpu_hold drops, bounded.
   task automatic wait_run(output int cycles);
      cycles = 0;
      while (cpu_hold && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   task automatic read_at(input logic [31:0] a, output logic [31:0] d);
      bus.Addr = a;
      #1;
      d = bus.ReadData;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      read_at(BASE, d);
      n_checks++;
      if (bus.ld_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ld_ready got %b want 1", bus.ld_ready);
      end
      n_checks++;
      if (cpu_hold !== 1'b1) begin
         n_fail++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold);
      end
      n_checks++;
      if (load_count !== 4'd0) begin
         n_fail++; $display("FAIL reset_load_count got %0d want 0", load_count);
      end
      n_checks++;
      if (addr_fault !== 1'b0) begin
         n_fail++; $display("FAIL reset_addr_fault got %b want 0", addr_fault);
      end
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL reset_read_data got %h want 0", d);
      end
   endtask

   task automatic test_short_image();
      logic [31:0] exp_rd [5];
      logic [31:0] d;
      int cyc;
      exp_rd = '{32'd11, 32'd22, 32'd33, 32'd0, 32'd0};
      do_reset();
      load_word(32'd11, 1'b0);
      load_word(32'd22, 1'b0);
      load_word(32'd33, 1'b1);
      n_checks++;
      if (load_count !== 4'd3) begin
         n_fail++; $display("FAIL short_load_count got %0d want 3", load_count);
      end
      n_checks++;
      if (bus.ld_ready !== 1'b0 || cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL short_clear_flags got rdy=%b hold=%b want 0/1", bus.ld_ready, cpu_hold);
      end
      read_at(BASE, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL short_read_held got %h want 0", d);
      end
      wait_run(cyc);
      n_checks++;
      if (cyc !== 5) begin
         n_fail++; $display("FAIL short_clear_cycles got %0d want 5", cyc);
      end
      for (int i = 0; i < 4; i++) begin
         read_at(BASE + 32'(4 * i), d);
         n_checks++;
         if (d !== exp_rd[i]) begin
            n_fail++; $display("FAIL short_read_w%0d got %h want %h", i, d, exp_rd[i]);
         end
      end
      read_at(BASE + 32'h1c, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL short_read_w7 got %h want 0", d);
      end
      n_checks++;
      if (addr_fault !== 1'b0) begin
         n_fail++; $display("FAIL short_no_fault got %b want 0", addr_fault);
      end
   endtask

   task automatic test_full_image();
      logic [31:0] d;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         load_word(32'd100 + 32'(i), 1'b0);
      end
      n_checks++;
      if (cpu_hold !== 1'b0 || bus.ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_direct_run got hold=%b rdy=%b want 0/0", cpu_hold, bus.ld_ready);
      end
      load_word(32'h999, 1'b1);
      n_checks++;
      if (load_count !== 4'd8) begin
         n_fail++; $display("FAIL full_load_count got %0d want 8", load_count);
      end
      read_at(BASE, d);
      n_checks++;
      if (d !== 32'd100) begin
         n_fail++; $display("FAIL full_read_w0 got %h want %h", d, 32'd100);
      end
      read_at(BASE + 32'h1c, d);
      n_checks++;
      if (d !== 32'd107) begin
         n_fail++; $display("FAIL full_read_w7 got %h want %h", d, 32'd107);
      end
   endtask

   task automatic test_stalled();
      logic [31:0] d;
      int cyc;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         load_word(32'ha0 + 32'(k), k == 3);
         // Idle cycle with junk data and a stray ld_last that must be ignored.
         bus.ld_data = 32'hffff;
         bus.ld_last = 1'b1;
         tick();
         bus.ld_last = 1'b0;
      end
      n_checks++;
      if (load_count !== 4'd4) begin
         n_fail++; $display("FAIL stall_load_count got %0d want 4", load_count);
      end
      wait_run(cyc);
      // One idle cycle after the last accept already ran in CLEAR.
      n_checks++;
      if (cyc !== 3) begin
         n_fail++; $display("FAIL stall_clear_cycles got %0d want 3", cyc);
      end
      for (int i = 0; i < 5; i++) begin
         read_at(BASE + 32'(4 * i), d);
         n_checks++;
         if (d !== ((i < 4) ? 32'ha0 + 32'(i) : 32'h0)) begin
            n_fail++; $display("FAIL stall_read_w%0d got %h", i, d);
         end
      end
   endtask

   task automatic test_cpu_store();
      logic [31:0] d;
      bus.Addr      = BASE + 32'h10;
      bus.WriteData = 32'hdead_beef;
      bus.MemWrite  = 1'b1;
      tick();
      bus.MemWrite  = 1'b0;
      read_at(BASE + 32'h10, d);
      n_checks++;
      if (d !== 32'hdead_beef) begin
         n_fail++; $display("FAIL store_readback got %h want deadbeef", d);
      end
      n_checks++;
      if (addr_fault !== 1'b0) begin
         n_fail++; $display("FAIL store_no_fault got %b want 0", addr_fault);
      end
      bus.Addr      = BASE + 32'h20;
      bus.WriteData = 32'h1234_5678;
      bus.MemWrite  = 1'b1;
      #1;
      n_checks++;
      if (bus.ReadData !== 32'h0) begin
         n_fail++; $display("FAIL oor_read_zero got %h want 0", bus.ReadData);
      end
      tick();
      bus.MemWrite = 1'b0;
      read_at(BASE, d);
      n_checks++;
      if (addr_fault !== 1'b1) begin
         n_fail++; $display("FAIL oor_fault got %b want 1", addr_fault);
      end
      n_checks++;
      if (d !== 32'ha0) begin
         n_fail++; $display("FAIL oor_dropped got %h want a0", d);
      end
   endtask

   task automatic test_reset_mid_clear();
      logic [31:0] d;
      int cyc;
      do_reset();
      load_word(32'd1, 1'b0);
      load_word(32'd2, 1'b0);
      load_word(32'd3, 1'b1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (bus.ld_ready !== 1'b1 || cpu_hold !== 1'b1 || load_count !== 4'd0) begin
         n_fail++;
         $display("FAIL midclear_reset got rdy=%b hold=%b cnt=%0d want 1/1/0",
                  bus.ld_ready, cpu_hold, load_count);
      end
      load_word(32'h55, 1'b0);
      load_word(32'h66, 1'b1);
      wait_run(cyc);
      n_checks++;
      if (cyc !== 6) begin
         n_fail++; $display("FAIL midclear_clear_cycles got %0d want 6", cyc);
      end
      read_at(BASE, d);
      n_checks++;
      if (d !== 32'h55) begin
         n_fail++; $display("FAIL midclear_w0 got %h want 55", d);
      end
      read_at(BASE + 32'h4, d);
      n_checks++;
      if (d !== 32'h66) begin
         n_fail++; $display("FAIL midclear_w1 got %h want 66", d);
      end
      read_at(BASE + 32'h8, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_fail++; $display("FAIL midclear_w2 got %h want 0", d);
      end
   endtask

   task automatic test_align();
      logic [31:0] d;
      logic [31:0] exp_w1;
      logic        exp_fault;
      int cyc;
`ifdef DMEM_ALIGN_CHECK_EN
      exp_w1    = 32'h20;
      exp_fault = 1'b1;
`else
      exp_w1    = 32'hcafe_f00d;
      exp_fault = 1'b0;
`endif
      do_reset();
      load_word(32'h10, 1'b0);
      load_word(32'h20, 1'b1);
      wait_run(cyc);
      bus.Addr      = BASE + 32'h6;
      bus.WriteData = 32'hcafe_f00d;
      bus.MemWrite  = 1'b1;
      tick();
      bus.MemWrite  = 1'b0;
      read_at(BASE + 32'h4, d);
      n_checks++;
      if (d !== exp_w1) begin
         n_fail++; $display("FAIL align_w1 got %h want %h", d, exp_w1);
      end
      n_checks++;
      if (addr_fault !== exp_fault) begin
         n_fail++; $display("FAIL align_fault got %b want %b", addr_fault, exp_fault);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_short_image();
      test_full_image();
      test_stalled();
      test_cpu_store();
      test_reset_mid_clear();
      test_align();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
